// File: rtl/avalon_master_mm_transfer_if.sv
// Avalon-MM bus bundle used by avalon_master_mm_transfer.
//   master modport : drives address/read/write/writedata/byteenable,
//                    receives readdata/waitrequest.
//   slave modport  : the mirror image, for a slave model or interconnect.
interface avalon_master_mm_transfer_if;
    logic [31:0] av_address;
    logic        av_read;
    logic        av_write;
    logic [31:0] av_writedata;
    logic [3:0]  av_byteenable;
    logic [31:0] av_readdata;
    logic        av_waitrequest;

    modport master (
        output av_address, av_read, av_write, av_writedata, av_byteenable,
        input  av_readdata, av_waitrequest
    );

    modport slave (
        input  av_address, av_read, av_write, av_writedata, av_byteenable,
        output av_readdata, av_waitrequest
    );
endinterface

// File: rtl/avalon_master_mm_transfer.sv
// Avalon-MM burst-less word mover: reads `length` 32-bit words starting at
// base_addr into the rd_* stream, or writes `length` words taken from the
// wr_* stream, one bus command per word.
//
// Ports:
//   clock, reset      rising-edge clock, synchronous active-high reset
//   start/dir         request a transfer (sampled in IDLE); 0 = read, 1 = write
//   base_addr/length  first byte address / number of words
//   busy/done/error   status: not idle / one-cycle end pulse / sticky timeout
//   wr_data/wr_valid/wr_ready   user write stream (ready only while fetching)
//   rd_data/rd_valid            user read stream (no backpressure)
//   av                Avalon-MM master bus (avalon_master_mm_transfer_if.master)
//
// Optional feature: define AMM_TIMEOUT_EN to abort a command after
// TIMEOUT_CYCLES consecutive waitrequest-stalled cycles (sets error).
// Without it ISSUE waits forever and error is tied low.
module avalon_master_mm_transfer #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        dir,
    input  logic [31:0] base_addr,
    input  logic [15:0] length,
    output logic        busy,
    output logic        done,
    output logic        error,
    input  logic [31:0] wr_data,
    input  logic        wr_valid,
    output logic        wr_ready,
    output logic [31:0] rd_data,
    output logic        rd_valid,
    avalon_master_mm_transfer_if.master av
);

    typedef enum logic [1:0] {IDLE, FETCH, ISSUE, DONE} state_t;

    state_t      state_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic [15:0] remaining_q;
    logic        dir_q;
    logic        busy_q;
    logic        done_q;
    logic        rd_cmd_q;
    logic        wr_cmd_q;
    logic        wr_ready_q;
    logic        rd_valid_q;

    logic [31:0] addr_d;
    logic [15:0] remaining_d;
    logic        accept;

    assign addr_d      = addr_q + 32'd4;          // wraps modulo 2^32
    assign remaining_d = remaining_q - 16'd1;
    // Command strobes are only ever high in ISSUE, so this is ISSUE-qualified.
    assign accept      = (rd_cmd_q | wr_cmd_q) & ~av.av_waitrequest;

`ifdef AMM_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CNT_W-1:0] stall_q;
    logic             error_q;
    assign error = error_q;
`else
    assign error = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            remaining_q <= '0;
            dir_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_cmd_q    <= 1'b0;
            wr_cmd_q    <= 1'b0;
            wr_ready_q  <= 1'b0;
            rd_valid_q  <= 1'b0;
`ifdef AMM_TIMEOUT_EN
            stall_q     <= '0;
            error_q     <= 1'b0;
`endif
        end else begin
            done_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        addr_q      <= base_addr;
                        remaining_q <= length;
                        dir_q       <= dir;
                        busy_q      <= 1'b1;
`ifdef AMM_TIMEOUT_EN
                        error_q     <= 1'b0;
                        stall_q     <= '0;
`endif
                        if (length == 16'd0) begin
                            state_q <= DONE;
                        end else if (dir) begin
                            state_q    <= FETCH;
                            wr_ready_q <= 1'b1;
                        end else begin
                            state_q  <= ISSUE;
                            rd_cmd_q <= 1'b1;
                        end
                    end
                end
                FETCH: begin
                    if (wr_valid) begin
                        wdata_q    <= wr_data;
                        wr_ready_q <= 1'b0;
                        wr_cmd_q   <= 1'b1;
                        state_q    <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (accept) begin
                        addr_q      <= addr_d;
                        remaining_q <= remaining_d;
`ifdef AMM_TIMEOUT_EN
                        stall_q     <= '0;
`endif
                        if (!dir_q) begin
                            rdata_q    <= av.av_readdata;
                            rd_valid_q <= 1'b1;
                        end
                        if (remaining_q == 16'd1) begin
                            rd_cmd_q <= 1'b0;
                            wr_cmd_q <= 1'b0;
                            state_q  <= DONE;
                        end else if (dir_q) begin
                            // Writes go back for the next stream word.
                            wr_cmd_q   <= 1'b0;
                            wr_ready_q <= 1'b1;
                            state_q    <= FETCH;
                        end
                    end
`ifdef AMM_TIMEOUT_EN
                    else if (stall_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        // This stall is the TIMEOUT_CYCLES-th: drop the command.
                        rd_cmd_q <= 1'b0;
                        wr_cmd_q <= 1'b0;
                        error_q  <= 1'b1;
                        stall_q  <= '0;
                        state_q  <= DONE;
                    end else begin
                        stall_q <= stall_q + 1'b1;
                    end
`endif
                end
                DONE: begin
                    // done is registered, so its pulse lands in the first IDLE cycle.
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy             = busy_q;
    assign done             = done_q;
    assign wr_ready         = wr_ready_q;
    assign rd_data          = rdata_q;
    assign rd_valid         = rd_valid_q;
    assign av.av_address    = addr_q;
    assign av.av_read       = rd_cmd_q;
    assign av.av_write      = wr_cmd_q;
    assign av.av_writedata  = wdata_q;
    assign av.av_byteenable = 4'b1111;

endmodule

// File: tb/tb_avalon_master_mm_transfer.sv
module tb_avalon_master_mm_transfer;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        dir;
    logic [31:0] base_addr;
    logic [15:0] length;
    logic        busy;
    logic        done;
    logic        error;
    logic [31:0] wr_data;
    logic        wr_valid;
    logic        wr_ready;
    logic [31:0] rd_data;
    logic        rd_valid;

    int unsigned pass_cnt = 0;
    int unsigned total_cnt = 0;

    avalon_master_mm_transfer_if av_if ();

    avalon_master_mm_transfer #(.TIMEOUT_CYCLES(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .dir       (dir),
        .base_addr (base_addr),
        .length    (length),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .wr_data   (wr_data),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .av        (av_if)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Advance one cycle; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; dir = 1'b0; base_addr = '0; length = '0;
        wr_data = '0; wr_valid = 1'b0;
        av_if.av_readdata = '0; av_if.av_waitrequest = 1'b0;
        tick(); tick();
        total_cnt++;
        if ({busy, done, error, av_if.av_read, av_if.av_write, wr_ready, rd_valid} !== 7'b0)
            $display("FAIL reset_ctrl: got %b want 0000000", {busy, done, error, av_if.av_read, av_if.av_write, wr_ready, rd_valid});
        else pass_cnt++;
        total_cnt++;
        if ({av_if.av_address, av_if.av_writedata, rd_data, av_if.av_byteenable} !== {96'h0, 4'hF})
            $display("FAIL reset_data: got %h %h %h %h want 0 0 0 f", av_if.av_address, av_if.av_writedata, rd_data, av_if.av_byteenable);
        else pass_cnt++;
        reset = 1'b0;
        tick();
    endtask

    // base 0x1000, 3 words, zero wait: back-to-back reads then one done pulse.
    task automatic test_read_burst();
        logic [31:0] exp_data [3];
        exp_data[0] = 32'hA; exp_data[1] = 32'hB; exp_data[2] = 32'hC;
        base_addr = 32'h1000; length = 16'd3; dir = 1'b0; start = 1'b1;
        av_if.av_waitrequest = 1'b0;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            av_if.av_readdata = exp_data[i];
            total_cnt++;
            if ({av_if.av_read, av_if.av_write, busy, av_if.av_address} !== {3'b101, 32'h1000 + 32'(4 * i)})
                $display("FAIL rd_cmd%0d: got rd=%b wr=%b busy=%b addr=%h want 1 0 1 %h", i, av_if.av_read, av_if.av_write, busy, av_if.av_address, 32'h1000 + 32'(4 * i));
            else pass_cnt++;
            if (i > 0) begin
                total_cnt++;
                if ({rd_valid, rd_data} !== {1'b1, exp_data[i-1]})
                    $display("FAIL rd_data%0d: got v=%b d=%h want 1 %h", i - 1, rd_valid, rd_data, exp_data[i-1]);
                else pass_cnt++;
            end
            tick();
        end
        total_cnt++;
        if ({av_if.av_read, rd_valid, rd_data, done, busy} !== {2'b01, 32'hC, 2'b01})
            $display("FAIL rd_last: got rd=%b v=%b d=%h done=%b busy=%b want 0 1 c 0 1", av_if.av_read, rd_valid, rd_data, done, busy);
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({done, busy, rd_valid} !== 3'b100)
            $display("FAIL rd_done: got done=%b busy=%b v=%b want 1 0 0", done, busy, rd_valid);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (done !== 1'b0) $display("FAIL rd_done_once: got %b want 0", done);
        else pass_cnt++;
    endtask

    // base 0x20, 2 words; first word stalled 3 cycles -> held 4 cycles.
    task automatic test_write_stall();
        base_addr = 32'h20; length = 16'd2; dir = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        total_cnt++;
        if ({wr_ready, av_if.av_write, av_if.av_read, busy} !== 4'b1001)
            $display("FAIL wr_fetch0: got rdy=%b wr=%b rd=%b busy=%b want 1 0 0 1", wr_ready, av_if.av_write, av_if.av_read, busy);
        else pass_cnt++;
        wr_data = 32'h11; wr_valid = 1'b1;
        tick();
        wr_valid = 1'b0; wr_data = 32'hDEAD;
        for (int i = 0; i < 4; i++) begin
            av_if.av_waitrequest = (i < 3);
            total_cnt++;
            if ({av_if.av_write, av_if.av_read, wr_ready, av_if.av_address, av_if.av_writedata} !== {3'b100, 32'h20, 32'h11})
                $display("FAIL wr_hold%0d: got wr=%b rd=%b rdy=%b addr=%h data=%h want 1 0 0 20 11", i, av_if.av_write, av_if.av_read, wr_ready, av_if.av_address, av_if.av_writedata);
            else pass_cnt++;
            tick();
        end
        total_cnt++;
        if ({wr_ready, av_if.av_write, av_if.av_address} !== {2'b10, 32'h24})
            $display("FAIL wr_fetch1: got rdy=%b wr=%b addr=%h want 1 0 24", wr_ready, av_if.av_write, av_if.av_address);
        else pass_cnt++;
        wr_data = 32'h22; wr_valid = 1'b1;
        tick();
        wr_valid = 1'b0;
        total_cnt++;
        if ({av_if.av_write, av_if.av_address, av_if.av_writedata} !== {1'b1, 32'h24, 32'h22})
            $display("FAIL wr_cmd1: got wr=%b addr=%h data=%h want 1 24 22", av_if.av_write, av_if.av_address, av_if.av_writedata);
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({av_if.av_write, done, rd_valid} !== 3'b000)
            $display("FAIL wr_end: got wr=%b done=%b rdv=%b want 0 0 0", av_if.av_write, done, rd_valid);
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({done, busy} !== 2'b10) $display("FAIL wr_done: got done=%b busy=%b want 1 0", done, busy);
        else pass_cnt++;
        tick();
    endtask

    // length 0: no bus command, done in cycle N+2.
    task automatic test_zero_length();
        base_addr = 32'h500; length = 16'd0; dir = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        total_cnt++;
        if ({done, busy, av_if.av_read, av_if.av_write, wr_ready} !== 5'b01000)
            $display("FAIL zl_n1: got done=%b busy=%b rd=%b wr=%b rdy=%b want 0 1 0 0 0", done, busy, av_if.av_read, av_if.av_write, wr_ready);
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({done, busy, av_if.av_read, av_if.av_write} !== 4'b1000)
            $display("FAIL zl_n2: got done=%b busy=%b rd=%b wr=%b want 1 0 0 0", done, busy, av_if.av_read, av_if.av_write);
        else pass_cnt++;
        tick();
    endtask

    // base 0xFFFFFFFC, 2 reads: second address wraps to 0.
    task automatic test_wrap();
        base_addr = 32'hFFFF_FFFC; length = 16'd2; dir = 1'b0; start = 1'b1;
        av_if.av_waitrequest = 1'b0; av_if.av_readdata = 32'h5;
        tick();
        start = 1'b0;
        total_cnt++;
        if ({av_if.av_read, av_if.av_address} !== {1'b1, 32'hFFFF_FFFC})
            $display("FAIL wrap_a0: got rd=%b addr=%h want 1 fffffffc", av_if.av_read, av_if.av_address);
        else pass_cnt++;
        tick();
        av_if.av_readdata = 32'h6;
        total_cnt++;
        if ({av_if.av_read, av_if.av_address, rd_valid, rd_data} !== {1'b1, 32'h0, 1'b1, 32'h5})
            $display("FAIL wrap_a1: got rd=%b addr=%h v=%b d=%h want 1 0 1 5", av_if.av_read, av_if.av_address, rd_valid, rd_data);
        else pass_cnt++;
        tick(); tick();
        total_cnt++;
        if (done !== 1'b1) $display("FAIL wrap_done: got %b want 1", done);
        else pass_cnt++;
        tick();
    endtask

    // Waitrequest stuck high on a single-word read.
    task automatic test_timeout();
        base_addr = 32'h40; length = 16'd1; dir = 1'b0; start = 1'b1;
        av_if.av_waitrequest = 1'b1;
        tick();
        start = 1'b0;
`ifdef AMM_TIMEOUT_EN
        for (int i = 0; i < 4; i++) begin
            total_cnt++;
            if ({av_if.av_read, error} !== 2'b10)
                $display("FAIL to_stall%0d: got rd=%b err=%b want 1 0", i, av_if.av_read, error);
            else pass_cnt++;
            tick();
        end
        total_cnt++;
        if ({av_if.av_read, error, done, rd_valid, av_if.av_address} !== {4'b0100, 32'h40})
            $display("FAIL to_drop: got rd=%b err=%b done=%b v=%b addr=%h want 0 1 0 0 40", av_if.av_read, error, done, rd_valid, av_if.av_address);
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({done, error, busy} !== 3'b110) $display("FAIL to_done: got done=%b err=%b busy=%b want 1 1 0", done, error, busy);
        else pass_cnt++;
        av_if.av_waitrequest = 1'b0;
        length = 16'd0; start = 1'b1;
        tick();
        start = 1'b0;
        total_cnt++;
        if (error !== 1'b0) $display("FAIL to_clear: got err=%b want 0", error);
        else pass_cnt++;
        tick(); tick();
`else
        for (int i = 0; i < 10; i++) tick();
        total_cnt++;
        if ({av_if.av_read, error, done, busy} !== 4'b1001)
            $display("FAIL nto_wait: got rd=%b err=%b done=%b busy=%b want 1 0 0 1", av_if.av_read, error, done, busy);
        else pass_cnt++;
        av_if.av_waitrequest = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
`endif
    endtask

    // Reset after 2 of 5 reads; a start while busy is ignored.
    task automatic test_reset_mid();
        base_addr = 32'h100; length = 16'd5; dir = 1'b0; start = 1'b1;
        av_if.av_waitrequest = 1'b0; av_if.av_readdata = 32'h77;
        tick();
        base_addr = 32'h9000; length = 16'd0; dir = 1'b1;   // start stays high: must be ignored
        tick(); tick();
        total_cnt++;
        if ({av_if.av_read, av_if.av_write, av_if.av_address, busy} !== {2'b10, 32'h108, 1'b1})
            $display("FAIL busy_start: got rd=%b wr=%b addr=%h busy=%b want 1 0 108 1", av_if.av_read, av_if.av_write, av_if.av_address, busy);
        else pass_cnt++;
        start = 1'b0;
        reset = 1'b1;
        tick();
        total_cnt++;
        if ({av_if.av_read, av_if.av_write, busy, done, rd_valid, wr_ready, av_if.av_address, rd_data, av_if.av_byteenable} !== {6'b0, 64'h0, 4'hF})
            $display("FAIL rst_mid: got rd=%b wr=%b busy=%b done=%b v=%b rdy=%b addr=%h d=%h be=%h", av_if.av_read, av_if.av_write, busy, done, rd_valid, wr_ready, av_if.av_address, rd_data, av_if.av_byteenable);
        else pass_cnt++;
        reset = 1'b0;
        tick();
        total_cnt++;
        if ({av_if.av_read, done, rd_valid, busy} !== 4'b0)
            $display("FAIL rst_after: got rd=%b done=%b v=%b busy=%b want 0 0 0 0", av_if.av_read, done, rd_valid, busy);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_read_burst();
        test_write_stall();
        test_zero_length();
        test_wrap();
        test_timeout();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
